// File: rtl/piso_stream_ser.sv
// Parallel-in / serial-out stream serialiser with valid/ready handshakes on both sides.
// A one-word hold buffer sits behind the shift register so consecutive words stream without gaps.
module piso_stream_ser #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 1,
   parameter int MSB_FIRST  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [LANES-1:0]      dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  dout_last,
   output logic                  busy
);

   localparam int N  = DATA_WIDTH / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   logic                  active_q, active_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  holdValid_q, holdValid_d;

   logic inHs;
   logic outHs;
   logic free;

   assign din_ready  = ~holdValid_q;
   assign dout_valid = active_q;
   assign dout_last  = active_q & (cnt_q == LAST_CNT);
   assign busy       = active_q | holdValid_q;

   assign inHs  = din_valid & ~holdValid_q;
   assign outHs = active_q & dout_ready;
   assign free  = ~active_q | (dout_last & dout_ready);

   always_comb begin
      dout = '0;
      if (active_q) begin
         if (MSB_FIRST != 0) dout = shift_q[DATA_WIDTH-1 -: LANES];
         else                dout = shift_q[LANES-1:0];
      end
   end

   // The shift register refills from the hold buffer first so word order is preserved;
   // a word only bypasses straight into the shift register when nothing is held.
   always_comb begin
      active_d    = active_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      holdValid_d = holdValid_q;
      if (free) begin
         if (holdValid_q) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            active_d    = 1'b1;
            holdValid_d = 1'b0;
            if (inHs) begin
               hold_d      = din;
               holdValid_d = 1'b1;
            end
         end else if (inHs) begin
            shift_d  = din;
            cnt_d    = '0;
            active_d = 1'b1;
         end else begin
            shift_d  = '0;
            cnt_d    = '0;
            active_d = 1'b0;
         end
      end else begin
         if (outHs) begin
            if (MSB_FIRST != 0) shift_d = shift_q << LANES;
            else                shift_d = shift_q >> LANES;
            cnt_d = cnt_q + CW'(1);
         end
         if (inHs) begin
            hold_d      = din;
            holdValid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         active_q    <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         holdValid_q <= 1'b0;
      end else begin
         active_q    <= active_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         holdValid_q <= holdValid_d;
      end
   end

endmodule
